serial_uart_bridge: RTL and testbench

Buffered 8N1 UART bridge that sits directly downstream of the datapath's serial port (serial_out / serial_wren_out / serial_rden_out) and feeds its serial_in / serial_valid_in / serial_ready_in inputs. Bytes written by store instructions to the serial address are queued in a TX FIFO and serialized onto uart_txd. Bytes arriving on uart_rxd are deserialized into an RX FIFO and presented first-word-fall-through to the data memory's load path.

---
 rtl/serial_uart_bridge.sv | 268 ++++++++++++++++++++++++++
 tb/tb_serial_uart_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_uart_bridge.sv
// Buffered 8N1 UART bridge between the datapath serial port and a UART pin pair.
// TX FIFO feeds a frame serializer; the RX deserializer feeds a first-word-fall-through FIFO.
module serial_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_wr_data,
  input  logic       cpu_wr_en,
  input  logic       cpu_rd_en,
  output logic       cpu_wr_ready,
  output logic [7:0] cpu_rd_data,
  output logic       cpu_rd_valid,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wptr_q, tx_rptr_q;
  logic [CNT_W-1:0] tx_count_q;
  logic             tx_push_c, tx_pop_c, tx_empty_c;
  logic [7:0]       tx_head_c;

  assign tx_push_c    = cpu_wr_en && (tx_count_q != FULL);
  assign tx_empty_c   = (tx_count_q == '0);
  assign tx_head_c    = tx_mem_q[tx_rptr_q];
  assign cpu_wr_ready = (tx_count_q != FULL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_push_c) tx_wptr_q <= tx_wptr_q + PTR_W'(1);
      if (tx_pop_c)  tx_rptr_q <= tx_rptr_q + PTR_W'(1);
      tx_count_q <= tx_count_q + CNT_W'(tx_push_c) - CNT_W'(tx_pop_c);
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push_c) tx_mem_q[tx_wptr_q] <= cpu_wr_data;
  end

  // ---------------------------------------------------------------- TX FSM
  state_e            tx_state_q, tx_state_d;
  logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic              txd_q, txd_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_baud_done_c;

  assign tx_baud_done_c = (tx_cnt_q == BAUD_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      S_IDLE:  if (!tx_empty_c)     tx_state_d = S_START;
      S_START: if (tx_baud_done_c)  tx_state_d = S_DATA;
      S_DATA:  if (tx_baud_done_c && tx_bit_q == 3'd7) tx_state_d = S_STOP;
      S_STOP:  if (tx_baud_done_c)  tx_state_d = tx_empty_c ? S_IDLE : S_START;
      default:                      tx_state_d = S_IDLE;
    endcase
  end

  // STOP reloads straight into START when more bytes wait, so frames abut.
  always_comb begin
    tx_cnt_d  = tx_cnt_q + BAUD_W'(1);
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    txd_d     = txd_q;
    tx_pop_c  = 1'b0;
    tx_busy_d = (tx_state_d != S_IDLE);
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty_c) begin
          tx_pop_c = 1'b1;
          tx_sh_d  = tx_head_c;
          txd_d    = 1'b0;
        end
      end
      S_START: begin
        if (tx_baud_done_c) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          txd_d    = tx_sh_q[0];
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        end
      end
      S_DATA: begin
        if (tx_baud_done_c) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            txd_d   = tx_sh_q[0];
            tx_sh_d = {1'b0, tx_sh_q[7:1]};
          end
        end
      end
      S_STOP: begin
        if (tx_baud_done_c) begin
          tx_cnt_d = '0;
          if (!tx_empty_c) begin
            tx_pop_c = 1'b1;
            tx_sh_d  = tx_head_c;
            txd_d    = 1'b0;
          end
        end
      end
      default: tx_cnt_d = '0;
    endcase
  end

  assign uart_txd = txd_q;
  assign tx_busy  = tx_busy_q;

  // ---------------------------------------------------------------- RX FSM
  logic [1:0]        sync_q;
  logic              rxs_c, rxs_prev_q;
  state_e            rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic              rx_stop_c;
  logic              overrun_q, frame_err_q;

  assign rxs_c = sync_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      sync_q     <= {sync_q[0], uart_rxd};
      rxs_prev_q <= rxs_c;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      S_IDLE:  if (rxs_prev_q && !rxs_c) rx_state_d = S_START;
      S_START: if (rx_cnt_q == BAUD_MID) rx_state_d = rxs_c ? S_IDLE : S_DATA;
      S_DATA:  if (rx_cnt_q == BAUD_LAST && rx_bit_q == 3'd7) rx_state_d = S_STOP;
      S_STOP:  if (rx_cnt_q == BAUD_LAST) rx_state_d = S_IDLE;
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Counter restarts at start-bit mid-point, so every later wrap lands mid-bit.
  always_comb begin
    rx_cnt_d  = rx_cnt_q + BAUD_W'(1);
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_stop_c = 1'b0;
    case (rx_state_q)
      S_IDLE: rx_cnt_d = '0;
      S_START: begin
        if (rx_cnt_q == BAUD_MID) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = rx_bit_q + 3'd1;
          rx_sh_d  = {rxs_c, rx_sh_q[7:1]};
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d  = '0;
          rx_stop_c = 1'b1;
        end
      end
      default: rx_cnt_d = '0;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wptr_q, rx_rptr_q;
  logic [CNT_W-1:0] rx_count_q;
  logic             rx_full_c, rx_empty_c, rx_good_c, rx_push_c, rx_pop_c;

  assign rx_full_c  = (rx_count_q == FULL);
  assign rx_empty_c = (rx_count_q == '0);
  assign rx_good_c  = rx_stop_c && rxs_c;
  assign rx_pop_c   = cpu_rd_en && !rx_empty_c;
  assign rx_push_c  = rx_good_c && (!rx_full_c || cpu_rd_en);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_count_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (rx_push_c) rx_wptr_q <= rx_wptr_q + PTR_W'(1);
      if (rx_pop_c)  rx_rptr_q <= rx_rptr_q + PTR_W'(1);
      rx_count_q <= rx_count_q + CNT_W'(rx_push_c) - CNT_W'(rx_pop_c);
      if (rx_good_c && rx_full_c && !cpu_rd_en) overrun_q <= 1'b1;
      if (rx_stop_c && !rxs_c)                  frame_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push_c) rx_mem_q[rx_wptr_q] <= rx_sh_q;
  end

  assign cpu_rd_valid = !rx_empty_c;
  assign cpu_rd_data  = rx_empty_c ? 8'h00 : rx_mem_q[rx_rptr_q];
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed-plus-random bench for serial_uart_bridge with a queue-based UART model.
// TX pins are checked every cycle against frames predicted from the byte queue.
module tb_serial_uart_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock, reset;
  logic [7:0] cpu_wr_data;
  logic       cpu_wr_en, cpu_rd_en;
  logic       cpu_wr_ready;
  logic [7:0] cpu_rd_data;
  logic       cpu_rd_valid;
  logic       uart_rxd, uart_txd, tx_busy, rx_overrun, rx_frame_err;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_en(cpu_wr_en), .cpu_rd_en(cpu_rd_en),
    .cpu_wr_ready(cpu_wr_ready), .cpu_rd_data(cpu_rd_data), .cpu_rd_valid(cpu_rd_valid),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd), .tx_busy(tx_busy),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         vectors = 0;
  int         miscompares = 0;
  int         edge_n = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       tx_active;
  logic [7:0] tx_cur;
  int         tx_start;
  logic       exp_ovr, exp_ferr;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[idx];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    tx_active = 1'b0;
    tx_cur    = 8'h00;
    tx_start  = 0;
    exp_ovr   = 1'b0;
    exp_ferr  = 1'b0;
  endtask

  task automatic rst_check(input string when);
    chk({when, "_txd"},     8'(uart_txd),     8'h01);
    chk({when, "_wrready"}, 8'(cpu_wr_ready), 8'h01);
    chk({when, "_rdvalid"}, 8'(cpu_rd_valid), 8'h00);
    chk({when, "_rddata"},  cpu_rd_data,      8'h00);
    chk({when, "_busy"},    8'(tx_busy),      8'h00);
    chk({when, "_overrun"}, 8'(rx_overrun),   8'h00);
    chk({when, "_frmerr"},  8'(rx_frame_err), 8'h00);
  endtask

  // One clock: the transmitter takes a waiting byte whenever it is idle or a frame just ended.
  task automatic step(input logic we, input logic [7:0] d, input logic re);
    int   pre;
    logic exp_txd;
    cpu_wr_en   = we;
    cpu_wr_data = d;
    cpu_rd_en   = re;
    edge_n++;
    pre = txq.size();
    if (tx_active && edge_n == tx_start + FRAME) tx_active = 1'b0;
    if (!tx_active && pre > 0) begin
      tx_cur    = txq.pop_front();
      tx_start  = edge_n;
      tx_active = 1'b1;
    end
    if (we && pre < DEPTH) txq.push_back(d);
    if (re && rxq.size() > 0) void'(rxq.pop_front());
    @(posedge clock);
    #1;
    cpu_wr_en = 1'b0;
    cpu_rd_en = 1'b0;
    exp_txd = tx_active ? frame_bit(tx_cur, (edge_n - tx_start) / CPB) : 1'b1;
    chk("uart_txd",     8'(uart_txd),     8'(exp_txd));
    chk("tx_busy",      8'(tx_busy),      8'(tx_active));
    chk("cpu_wr_ready", 8'(cpu_wr_ready), 8'(txq.size() != DEPTH));
  endtask

  task automatic rx_check(input string tag);
    chk({tag, "_rdvalid"}, 8'(cpu_rd_valid), 8'(rxq.size() > 0));
    chk({tag, "_rddata"},  cpu_rd_data,      (rxq.size() > 0) ? rxq[0] : 8'h00);
    chk({tag, "_overrun"}, 8'(rx_overrun),   8'(exp_ovr));
    chk({tag, "_frmerr"},  8'(rx_frame_err), 8'(exp_ferr));
  endtask

  // Drives one 8N1 frame plus one idle bit time; the byte lands in the model if the stop bit is high.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = (i == 9) ? stop : frame_bit(b, i);
      repeat (CPB) step(1'b0, 8'h00, 1'b0);
    end
    uart_rxd = 1'b1;
    repeat (CPB) step(1'b0, 8'h00, 1'b0);
    if (!stop)                  exp_ferr = 1'b1;
    else if (rxq.size() < DEPTH) rxq.push_back(b);
    else                        exp_ovr = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    cpu_wr_data = 8'h00;
    cpu_wr_en   = 1'b0;
    cpu_rd_en   = 1'b0;
    uart_rxd    = 1'b1;
    model_reset();

    #2 reset = 1'b0;
    #1 rst_check("por");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Single byte from the example frame.
    step(1'b1, 8'hA5, 1'b0);
    repeat (FRAME + 3) step(1'b0, 8'h00, 1'b0);

    // Six pushes on consecutive cycles into a depth-4 FIFO: five fit, one is lost.
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0);
    repeat (5 * FRAME + 5) step(1'b0, 8'h00, 1'b0);

    // Random bytes with random gaps.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 50)) step(1'b0, 8'h00, 1'b0);
    end
    repeat (4 * FRAME + 5) step(1'b0, 8'h00, 1'b0);

    // RX byte then pop.
    send_frame(8'h3C, 1'b1);
    rx_check("rx3c");
    step(1'b0, 8'h00, 1'b1);
    rx_check("rx_pop");

    // One-cycle low glitch.
    uart_rxd = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    uart_rxd = 1'b1;
    repeat (3 * CPB + 10) step(1'b0, 8'h00, 1'b0);
    rx_check("glitch");

    // Five frames without reads.
    for (int k = 0; k < 5; k++) send_frame(8'($urandom), 1'b1);
    rx_check("ovr_fill");
    for (int k = 0; k < 4; k++) begin
      rx_check("ovr_read");
      step(1'b0, 8'h00, 1'b1);
    end
    rx_check("ovr_empty");

    // Bad stop bit.
    send_frame(8'($urandom), 1'b0);
    rx_check("frmerr");

    // Reset in the middle of the third data bit of a frame.
    step(1'b1, 8'($urandom), 1'b0);
    repeat (1 + 3 * CPB + CPB / 2 - 1) step(1'b0, 8'h00, 1'b0);
    #2 reset = 1'b0;
    #1 rst_check("midrst");
    @(posedge clock);
    #1 reset = 1'b1;
    model_reset();
    step(1'b1, 8'($urandom), 1'b0);
    repeat (FRAME + 3) step(1'b0, 8'h00, 1'b0);
    rx_check("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
